seq_card_tx: RTL and testbench

Transmit side of the card-sequence link. Accepts 4-bit cards one at a time from an upstream source, grouped into hands by a last flag. Buffers each hand until it is complete, then replays it as one contiguous valid burst in the format the sequence checker consumes: `in_valid` high for exactly one hand, and card values 1..15. Every burst is separated from the next by at least one idle cycle, because the checker clears its history on any valid-low cycle.

---
 rtl/seq_card_tx_pkg.sv | 20 ++
 rtl/seq_card_tx_if.sv | 27 ++
 rtl/seq_card_fifo.sv | 59 +++++
 rtl/seq_card_tx.sv | 110 +++++++++++
 tb/tb_seq_card_tx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_card_tx_pkg.sv
// Shared types for the card-sequence transmit path.
//   card_t      : 4-bit card value, legal range 1..15
//   seq_entry_t : buffered FIFO entry {last, card}
//   tx_state_e  : transmit FSM states
package seq_pkg;

   typedef logic [3:0] card_t;

   typedef struct packed {
      logic  last;
      card_t card;
   } seq_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } tx_state_e;

endpackage

// File: rtl/seq_card_tx_if.sv
// Bundle of the upstream card handshake, the checker-facing output and the
// error pulses of seq_card_tx.
//   master : upstream source / observer side
//   slave  : seq_card_tx side
interface seq_card_tx_if;
   import seq_pkg::*;

   logic  up_valid;
   logic  up_ready;
   card_t up_data;
   logic  up_last;
   logic  out_valid;
   card_t out_data;
   logic  err_zero;
   logic  err_ovf;

   modport master (
      output up_valid, up_data, up_last,
      input  up_ready, out_valid, out_data, err_zero, err_ovf
   );

   modport slave (
      input  up_valid, up_data, up_last,
      output up_ready, out_valid, out_data, err_zero, err_ovf
   );

endinterface

// File: rtl/seq_card_fifo.sv
// Circular buffer of {last, card} entries for seq_card_tx.
//   push/wdata       : write one entry at the write pointer
//   pop/rdata        : rdata shows the oldest entry; pop advances past it
//   set_last         : mark the most recently written entry as end of hand
//   rewind/rewind_ptr: move the write pointer back, dropping newer entries
//   count            : number of stored entries (0..DEPTH)
//   wptr             : current write pointer, used to track hand boundaries
module seq_card_fifo
   import seq_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          set_last,
   input  logic          rewind,
   input  logic [AW-1:0] rewind_ptr,
   input  seq_entry_t    wdata,
   output seq_entry_t    rdata,
   output logic [CW-1:0] count,
   output logic [AW-1:0] wptr
);

   seq_entry_t    mem [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] kept;

   assign rdata = mem[rptr];
   assign kept  = rewind_ptr - rptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         // A rewind only happens while no pop is in flight, so the surviving
         // occupancy is simply the distance from the read pointer.
         if (rewind) begin
            wptr  <= rewind_ptr;
            count <= {1'b0, kept};
         end else begin
            if (push) wptr <= wptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
         if (pop) rptr <= rptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
      if (set_last) mem[wptr - AW'(1)].last <= 1'b1;
   end

endmodule

// File: rtl/seq_card_tx.sv
// Transmit side of the card-sequence link. Buffers upstream cards until a hand
// is complete, then replays the hand as one contiguous out_valid burst, with at
// least one idle cycle between bursts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.up_*   : upstream card handshake (valid/ready/data/last)
//   bus.out_*  : registered card stream towards the sequence checker
//   bus.err_*  : one-cycle pulses for a dropped zero card / discarded hand
//
// state | meaning
// IDLE  | no burst; pops the first card as soon as a complete hand is buffered
// SEND  | popping one card per cycle until the entry flagged last
// GAP   | single forced idle cycle so the checker sees hands separately
module seq_card_tx
   import seq_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          rst_n,
   seq_card_tx_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   tx_state_e     state, state_nxt;
   logic [CW-1:0] count, hands;
   logic [AW-1:0] wptr, hand_start;
   logic          discarding;
   seq_entry_t    rdata, wdata;
   logic          xfer, zero_card, ovf_hit, push, pop, set_last, hand_done;

   assign bus.up_ready = (count < CW'(DEPTH)) || discarding;
   assign xfer         = bus.up_valid && bus.up_ready;
   assign zero_card    = (bus.up_data == '0);
   // A card waiting at a full FIFO that holds no complete hand can never be
   // accepted, so the partial hand is abandoned instead of deadlocking.
   assign ovf_hit      = bus.up_valid && !discarding &&
                         (count == CW'(DEPTH)) && (hands == '0);
   assign push         = xfer && !discarding && !zero_card;
   assign set_last     = xfer && !discarding && zero_card && bus.up_last &&
                         (wptr != hand_start);
   assign hand_done    = (push && bus.up_last) || set_last;
   assign wdata        = '{last: bus.up_last, card: bus.up_data};

   seq_card_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .set_last   (set_last),
      .rewind     (ovf_hit),
      .rewind_ptr (hand_start),
      .wdata      (wdata),
      .rdata      (rdata),
      .count      (count),
      .wptr       (wptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (hands != '0) begin
               pop       = 1'b1;
               state_nxt = rdata.last ? GAP : SEND;
            end
         end
         SEND: begin
            pop       = 1'b1;
            state_nxt = rdata.last ? GAP : SEND;
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hands        <= '0;
         hand_start   <= '0;
         discarding   <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.err_zero  <= 1'b0;
         bus.err_ovf   <= 1'b0;
      end else begin
         hands <= hands + CW'(hand_done) - CW'(pop && rdata.last);

         if (push && bus.up_last) hand_start <= wptr + AW'(1);
         else if (set_last)       hand_start <= wptr;

         if (ovf_hit)                                discarding <= 1'b1;
         else if (xfer && discarding && bus.up_last) discarding <= 1'b0;

         bus.out_valid <= pop;
         if (pop) bus.out_data <= rdata.card;

         bus.err_zero <= xfer && !discarding && zero_card;
         bus.err_ovf  <= ovf_hit;
      end
   end

endmodule

// File: tb/tb_seq_card_tx.sv
// Directed bench for seq_card_tx with DEPTH=16.
module tb_seq_card_tx;
   import seq_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   seq_card_tx_if ifc ();

   seq_card_tx #(.DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int oc[$];
   int od[$];
   int exp_q[$];
   int zc, zcyc, ovc, ovcyc;
   int last_t, last_wait;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.out_valid) begin
            oc.push_back(cyc);
            od.push_back(int'(ifc.out_data));
         end
         if (ifc.err_zero) begin
            zc++;
            zcyc = cyc;
         end
         if (ifc.err_ovf) begin
            ovc++;
            ovcyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear();
      oc.delete();
      od.delete();
      exp_q.delete();
      zc  = 0;
      ovc = 0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Presents one card at a negedge and holds it until accepted; records the
   // transfer cycle and how many cycles up_ready was low.
   task automatic send(input int card, input bit last);
      int n = 0;
      ifc.up_valid = 1'b1;
      ifc.up_data  = card_t'(card);
      ifc.up_last  = last;
      #1;
      while (!ifc.up_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!ifc.up_ready) check("send_timeout", 0, 1);
      last_t    = cyc;
      last_wait = n;
      @(negedge clk);
      ifc.up_valid = 1'b0;
      ifc.up_last  = 1'b0;
   endtask

   // Compares captured output against exp_q; cards are expected on
   // consecutive cycles from first_cyc, with one idle cycle after index
   // gap_after (negative: single burst).
   task automatic check_outs(input string tag, input int first_cyc, input int gap_after);
      int n;
      check({tag, "_len"}, oc.size(), exp_q.size());
      n = (oc.size() < exp_q.size()) ? oc.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data%0d", tag, i), od[i], exp_q[i]);
         check($sformatf("%s_cyc%0d", tag, i), oc[i],
               first_cyc + i + ((gap_after >= 0 && i > gap_after) ? 1 : 0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, tz, tw, n;
      ifc.up_valid = 1'b0;
      ifc.up_data  = '0;
      ifc.up_last  = 1'b0;
      zc = 0; zcyc = 0; ovc = 0; ovcyc = 0;
      repeat (3) @(negedge clk);

      check("rst_out_valid", int'(ifc.out_valid), 0);
      check("rst_out_data",  int'(ifc.out_data),  0);
      check("rst_err_zero",  int'(ifc.err_zero),  0);
      check("rst_err_ovf",   int'(ifc.err_ovf),   0);
      check("rst_up_ready",  int'(ifc.up_ready),  1);
      rst_n = 1'b1;
      @(negedge clk);

      // single hand, first card two cycles after the last transfer
      clear();
      send(3, 0); send(5, 0); send(9, 1);
      t = last_t;
      idle(10);
      exp_q = {3, 5, 9};
      check_outs("t1", t + 2, -1);

      // back-to-back hands: 3 high, 1 low, 3 high
      clear();
      send(2, 0); send(7, 0); send(4, 1);
      t = last_t;
      send(8, 0); send(6, 0); send(1, 1);
      idle(12);
      exp_q = {2, 7, 4, 8, 6, 1};
      check_outs("t2", t + 2, 2);

      // zero card in mid-hand
      clear();
      send(4, 0); send(0, 0);
      tz = last_t;
      send(6, 1);
      t = last_t;
      idle(10);
      check("t3a_zero_cnt", zc, 1);
      check("t3a_zero_cyc", zcyc, tz + 1);
      exp_q = {4, 6};
      check_outs("t3a", t + 2, -1);

      // zero card carrying last closes the hand
      clear();
      send(3, 0); send(0, 1);
      t = last_t;
      idle(10);
      check("t3b_zero_cnt", zc, 1);
      check("t3b_zero_cyc", zcyc, t + 1);
      exp_q = {3};
      check_outs("t3b", t + 2, -1);

      // 17-card hand overflows and is discarded
      clear();
      for (int i = 0; i < 16; i++) send(1, 0);
      send(1, 1);
      tw = last_wait;
      t  = last_t;
      idle(10);
      check("t4_ovf_cnt", ovc, 1);
      check("t4_ovf_cyc", ovcyc, t);
      check("t4_wait", tw, 1);
      check("t4_no_out", oc.size(), 0);

      clear();
      send(1, 0); send(2, 0); send(3, 1);
      t = last_t;
      idle(10);
      check("t4b_ovf_cnt", ovc, 0);
      exp_q = {1, 2, 3};
      check_outs("t4b", t + 2, -1);

      // full FIFO holding a complete hand back-pressures without overflow
      clear();
      for (int i = 0; i < 16; i++) begin
         send((i % 15) + 1, (i == 15));
         exp_q.push_back((i % 15) + 1);
      end
      t = last_t;
      send(5, 1);
      tw = last_wait;
      exp_q.push_back(5);
      idle(25);
      check("t5_wait", tw, 1);
      check("t5_ovf_cnt", ovc, 0);
      check_outs("t5", t + 2, 15);

      // reset during the second card of a 5-card burst
      clear();
      send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 1);
      n = 0;
      while (!(ifc.out_valid && ifc.out_data == 4'd2) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_second_card", int'(ifc.out_valid && ifc.out_data == 4'd2), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_out_valid", int'(ifc.out_valid), 0);
      check("t6_rst_up_ready",  int'(ifc.up_ready),  1);
      @(negedge clk);
      rst_n = 1'b1;
      clear();
      idle(15);
      check("t6_quiet", oc.size(), 0);
      send(7, 0); send(8, 1);
      t = last_t;
      idle(8);
      exp_q = {7, 8};
      check_outs("t6b", t + 2, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
